// File: rtl/bcd_scan_pkg.sv
// Shared glyph constants and sizing helper for the BCD scan display driver.
package bcd_scan_pkg;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bits needed to index 'value' distinct items
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = value - 32'd1;
        n = 0;
        while (v != 0) begin
            v = v >> 1;
            n = n + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_scan_driver_if.sv
// Load/busy handshake carrying new display data into the scan driver.
interface bcd_scan_driver_if #(
    parameter int unsigned DISPLAYS_NUM = 4,
    parameter int unsigned BRIGHT_W     = 3
);
    logic                      i_load;
    logic [4*DISPLAYS_NUM-1:0] i_bcd_data;
    logic [DISPLAYS_NUM-1:0]   i_dp;
    logic [BRIGHT_W-1:0]       i_bright;
    logic                      o_busy;

    modport master (output i_load, i_bcd_data, i_dp, i_bright, input o_busy);
    modport slave  (input i_load, i_bcd_data, i_dp, i_bright, output o_busy);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; active-high pattern, blank overrides.
module bcd_to_seg7
    import bcd_scan_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0:    seg_c = SEG_0;
                4'h1:    seg_c = SEG_1;
                4'h2:    seg_c = SEG_2;
                4'h3:    seg_c = SEG_3;
                4'h4:    seg_c = SEG_4;
                4'h5:    seg_c = SEG_5;
                4'h6:    seg_c = SEG_6;
                4'h7:    seg_c = SEG_7;
                4'h8:    seg_c = SEG_8;
                4'h9:    seg_c = SEG_9;
                4'hF:    seg_c = SEG_BLANK;
                default: seg_c = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// Time-multiplexed 7-segment driver with PWM brightness and frame-aligned data commit.
// Optional leading-zero blanking is built when BCD_SCAN_LZB_EN is defined.
module bcd_scan_driver
    import bcd_scan_pkg::*;
#(
    parameter int unsigned DISPLAYS_NUM   = 4,
    parameter int unsigned DIV_W          = 10,
    parameter int unsigned BRIGHT_W       = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    bcd_scan_driver_if.slave        bus,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [DISPLAYS_NUM-1:0] o_sel,
    output logic                    o_frame
);

    localparam int unsigned           DIG_W      = clogb2(DISPLAYS_NUM);
    localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(DISPLAYS_NUM - 1);
    localparam logic [BRIGHT_W-1:0]   BRIGHT_MAX = {BRIGHT_W{1'b1}};
    localparam logic [6:0]            SEG_INV    = {7{SEG_ACTIVE_LOW}};
    localparam logic [DISPLAYS_NUM-1:0] SEL_INV  = {DISPLAYS_NUM{SEL_ACTIVE_LOW}};

    logic [DIV_W-1:0]                  r_div;
    logic [DIG_W-1:0]                  r_digit;
    logic                              r_busy;
    logic [DISPLAYS_NUM-1:0][3:0]      pend_bcd, act_bcd;
    logic [DISPLAYS_NUM-1:0]           pend_dp, act_dp;
    logic [BRIGHT_W-1:0]               pend_bright, act_bright;

    logic                    slot_end_c;
    logic                    boundary_c;
    logic                    lit_c;
    logic                    cur_blank_c;
    logic [6:0]              glyph_c;
    logic [DISPLAYS_NUM-1:0] sel_hot_c;

    assign slot_end_c = (r_div == {DIV_W{1'b1}});
    assign boundary_c = slot_end_c && (r_digit == DIG_LAST);
    assign lit_c      = (act_bright == BRIGHT_MAX) ||
                        (r_div[DIV_W-1 -: BRIGHT_W] < act_bright);
    assign sel_hot_c  = DISPLAYS_NUM'(1) << r_digit;
    assign bus.o_busy = r_busy;

`ifdef BCD_SCAN_LZB_EN
    // Leading-zero mask from the top digit down; a set dp ends the run
    logic [DISPLAYS_NUM-1:0] lzb_mask_c;
    logic                    lzb_run_c;
    always_comb begin
        lzb_mask_c = '0;
        lzb_run_c  = 1'b1;
        for (int k = int'(DISPLAYS_NUM) - 1; k >= 1; k--) begin
            if (lzb_run_c && (act_bcd[k] == 4'd0) && !act_dp[k]) begin
                lzb_mask_c[k] = 1'b1;
            end else begin
                lzb_run_c = 1'b0;
            end
        end
    end
    assign cur_blank_c = lzb_mask_c[r_digit];
`else
    assign cur_blank_c = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .code  (act_bcd[r_digit]),
        .blank (cur_blank_c),
        .seg_c (glyph_c)
    );

    // Scan counters, double-buffered display data and registered pin drive
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div       <= '0;
            r_digit     <= '0;
            r_busy      <= 1'b0;
            pend_bcd    <= '0;
            pend_dp     <= '0;
            pend_bright <= '0;
            act_bcd     <= '0;
            act_dp      <= '0;
            act_bright  <= '0;
            o_seg       <= SEG_INV;
            o_dp        <= SEG_ACTIVE_LOW;
            o_sel       <= SEL_INV;
            o_frame     <= 1'b0;
        end else begin
            r_div <= r_div + DIV_W'(1);
            if (slot_end_c) begin
                r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
            end

            if (bus.i_load) begin
                pend_bcd    <= bus.i_bcd_data;
                pend_dp     <= bus.i_dp;
                pend_bright <= bus.i_bright;
            end

            if (boundary_c && bus.i_load) begin
                act_bcd    <= bus.i_bcd_data;
                act_dp     <= bus.i_dp;
                act_bright <= bus.i_bright;
                r_busy     <= 1'b0;
            end else if (boundary_c && r_busy) begin
                act_bcd    <= pend_bcd;
                act_dp     <= pend_dp;
                act_bright <= pend_bright;
                r_busy     <= 1'b0;
            end else if (bus.i_load) begin
                r_busy <= 1'b1;
            end

            o_frame <= boundary_c;
            o_seg   <= (lit_c ? glyph_c : 7'h00) ^ SEG_INV;
            o_dp    <= (lit_c && act_dp[r_digit]) ^ SEG_ACTIVE_LOW;
            o_sel   <= (lit_c ? sel_hot_c : '0) ^ SEL_INV;
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Randomised self-checking bench for bcd_scan_driver against a cycle-count reference model.
module tb_bcd_scan_driver;

    localparam int N        = 4;
    localparam int DIV_W    = 3;
    localparam int BRIGHT_W = 3;
    localparam int SLOT     = 8;
    localparam int FRAME    = 32;
`ifdef BCD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       frame;

    bcd_scan_driver_if #(.DISPLAYS_NUM(N), .BRIGHT_W(BRIGHT_W)) bus ();

    bcd_scan_driver #(
        .DISPLAYS_NUM(N), .DIV_W(DIV_W), .BRIGHT_W(BRIGHT_W),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_seg(seg), .o_dp(dp), .o_sel(sel), .o_frame(frame)
    );

    always #5 clk = ~clk;

    int          cyc;
    logic [15:0] m_act_data, m_pend_data;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic [2:0]  m_act_br, m_pend_br;
    bit          m_busy;
    int          last_frame;
    int          sel_cnt;
    int          n_pass;
    int          n_checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            4'hF: return 7'h00;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [3:0] lzb_mask(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] m;
        bit run;
        m = 4'b0000;
        run = 1'b1;
        if (LZB) begin
            for (int k = N - 1; k >= 1; k--) begin
                if (run && ((d >> (4 * k)) & 16'hF) == 16'h0 && !p[k]) m[k] = 1'b1;
                else run = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic model_reset();
        cyc = 0;
        m_act_data = '0; m_pend_data = '0;
        m_act_dp = '0;   m_pend_dp = '0;
        m_act_br = '0;   m_pend_br = '0;
        m_busy = 1'b0;
        last_frame = -1;
    endtask

    // One clock: predict outputs from the pre-edge position, advance, compare at negedge
    task automatic step();
        int div, dig;
        bit lit, bnd;
        logic [3:0] code, mask, x_sel;
        logic [6:0] x_seg;
        logic       x_dp;
        div  = cyc % SLOT;
        dig  = (cyc / SLOT) % N;
        bnd  = (div == SLOT - 1) && (dig == N - 1);
        code = 4'((m_act_data >> (4 * dig)) & 16'hF);
        mask = lzb_mask(m_act_data, m_act_dp);
        lit  = (m_act_br == 3'd7) || ((div >> (DIV_W - BRIGHT_W)) < int'(m_act_br));
        x_seg = ~((lit && !mask[dig]) ? glyph(code) : 7'h00);
        x_dp  = !(lit && m_act_dp[dig]);
        x_sel = ~(lit ? 4'(1 << dig) : 4'h0);
        @(posedge clk);
        if (bus.i_load && bnd) begin
            m_act_data = bus.i_bcd_data; m_act_dp = bus.i_dp; m_act_br = bus.i_bright;
            m_busy = 1'b0;
        end else if (bnd && m_busy) begin
            m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_br = m_pend_br;
            m_busy = 1'b0;
        end else if (bus.i_load) begin
            m_pend_data = bus.i_bcd_data; m_pend_dp = bus.i_dp; m_pend_br = bus.i_bright;
            m_busy = 1'b1;
        end
        cyc++;
        @(negedge clk);
        check("seg", 32'(seg), 32'(x_seg));
        check("dp", 32'(dp), 32'(x_dp));
        check("sel", 32'(sel), 32'(x_sel));
        check("frame", 32'(frame), 32'(bnd));
        check("busy", 32'(bus.o_busy), 32'(m_busy));
        if (sel != 4'hF) sel_cnt++;
        if (frame) begin
            if (last_frame >= 0) check("frame_period", 32'(cyc - last_frame), 32'(FRAME));
            last_frame = cyc;
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [2:0] b);
        bus.i_load = 1'b1; bus.i_bcd_data = d; bus.i_dp = p; bus.i_bright = b;
        step();
        bus.i_load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_phase(input int p);
        while (cyc % FRAME != p) step();
    endtask

    task automatic check_inactive(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_sel"}, 32'(sel), 32'hF);
        check({tag, "_frame"}, 32'(frame), 32'h0);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
    endtask

    initial begin
        n_pass = 0; n_checks = 0; sel_cnt = 0;
        bus.i_load = 1'b0; bus.i_bcd_data = '0; bus.i_dp = '0; bus.i_bright = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_inactive("reset");
        rst = 1'b1;

        // Basic scan of 1234 at full brightness
        load(16'h1234, 4'b0000, 3'd7);
        run(80);

        // Mid-frame load stays pending until the boundary
        wait_phase(9);
        load(16'h5678, 4'b0010, 3'd7);
        wait_phase(31);
        check("busy_hold", 32'(bus.o_busy), 32'h1);
        run(40);

        // Double load: last write wins
        wait_phase(10);
        load(16'h1111, 4'b0000, 3'd7);
        load(16'h2222, 4'b0000, 3'd7);
        run(40);

        // Load on the boundary cycle commits directly
        wait_phase(31);
        load(16'h4321, 4'b1000, 3'd7);
        check("coinc_busy", 32'(bus.o_busy), 32'h0);
        run(40);

        // PWM duty
        wait_phase(31);
        load(16'h8888, 4'b0000, 3'd2);
        wait_phase(0);
        sel_cnt = 0;
        run(32);
        check("duty_b2", 32'(sel_cnt), 32'd8);
        wait_phase(31);
        load(16'h8888, 4'b1111, 3'd0);
        wait_phase(0);
        sel_cnt = 0;
        run(32);
        check("duty_b0", 32'(sel_cnt), 32'd0);

        // Leading zeros, dp stopping the run, all-zero, dash and blank codes
        wait_phase(31); load(16'h0050, 4'b0000, 3'd7); run(32);
        wait_phase(31); load(16'h0050, 4'b0100, 3'd7); run(32);
        wait_phase(31); load(16'h0000, 4'b0000, 3'd7); run(32);
        wait_phase(31); load(16'hFA09, 4'b0101, 3'd5); run(40);

        // Random traffic
        repeat (400) begin
            if ($urandom_range(0, 9) == 0)
                load(16'($urandom), 4'($urandom), 3'($urandom));
            else
                step();
        end

        // Async reset mid-slot with data pending
        wait_phase(3);
        load(16'h9999, 4'b0000, 3'd7);
        run(2);
        #2 rst = 1'b0;
        #1 check_inactive("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        load(16'h9876, 4'b0001, 3'd7);
        run(72);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Parametrised time-multiplexed driver for a bank of 7-segment displays. It takes packed BCD digits plus per-digit decimal points, decodes them to segment patterns, scans the digits one at a time, and applies PWM brightness and optional leading-zero blanking. New display data passes through a load/busy handshake and is committed only at frame boundaries, so a digit never shows a mix of old and new values. It sits between the counter/datapath logic and the board pins, replacing the plain BCD scan multiplexer.

## Interface
- DISPLAYS_NUM, 4: number of digits, 2..16.
- DIV_W, 10: scan slot length is 2**DIV_W clocks per digit.
- BRIGHT_W, 3: width of the brightness code; DIV_W >= BRIGHT_W.
- SEG_ACTIVE_LOW, 1: 1 drives segments and dp active-low (common anode).
- SEL_ACTIVE_LOW, 1: 1 drives digit selects active-low.

Ports:
- i_clk  in  1  single system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_load  in  1  one-cycle request to capture the i_bcd_data / i_dp / i_bright inputs.
- i_bcd_data  in  4*DISPLAYS_NUM  digit k is in bits [4k+3:4k]; k=0 is the least-significant (rightmost) digit.
- i_dp  in  DISPLAYS_NUM  decimal point for digit k.
- i_bright  in  BRIGHT_W  duty code; 0 = dark, all-ones = fully on.
- o_busy  out  1  pending data captured but not yet committed.
- o_seg  out  7  segments, bit0=a … bit6=g.
- o_dp  out  1  decimal point.
- o_sel  out  DISPLAYS_NUM  one-hot digit enable.
- o_frame  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Slot counter.** r_div is DIV_W bits and free-running. At r_div == all-ones, r_digit advances, wrapping from DISPLAYS_NUM-1 to 0.
- **Frame boundary.** Occurs when r_div == all-ones and r_digit == DISPLAYS_NUM-1.
- **Buffering.** There are two register sets: pending and active.
  - i_load captures all inputs into pending and sets o_busy.
  - i_load while busy overwrites pending; last write wins.
  - At a frame boundary, if busy, pending is copied to active and busy clears.
  - If i_load coincides with a frame boundary, the incoming inputs go directly to active and busy stays 0.
- **Decode (active digit).**
  - 0–9: standard glyphs.
  - 0xA–0xE: dash (g only).
  - 0xF: blank.
  - dp comes from active dp[k].
- **Brightness.**
  - The digit is lit while r_div[DIV_W-1 -: BRIGHT_W] < active bright.
  - If bright is all-ones, the digit is lit for the whole slot.
  - When unlit, o_sel, o_seg and o_dp are all at their inactive level.
- **Polarity.** Output levels are inverted per SEG_ACTIVE_LOW / SEL_ACTIVE_LOW. Reset levels are the inactive levels.

## Timing
- Async reset values:
  - r_div = 0, r_digit = 0.
  - Pending and active are all zero (bright = 0, so the display is dark).
  - o_busy = 0, o_frame = 0.
  - o_sel, o_seg and o_dp all inactive.
- All outputs are registered. They reflect the r_div/r_digit state of the previous cycle (1-cycle latency).
- o_busy rises the cycle after i_load and falls the cycle after the committing boundary.
- Committed data is first visible on digit 0 in the slot that follows the boundary.
- o_frame is high for exactly one cycle, one cycle after each boundary. Period = DISPLAYS_NUM * 2**DIV_W clocks.
- Reset asserted mid-frame returns to digit 0 immediately. Pending data is discarded.

## Configuration
- **LZB enabled (BCD_SCAN_LZB_EN defined).**
  - Blanks leading zeros: digits with code 0, scanning from digit DISPLAYS_NUM-1 downward, are blanked.
  - Blanking stops at the first nonzero digit or the first digit with dp set.
  - Digit 0 is never blanked.
  - A blanked digit with dp=0 drives no segments; o_sel still follows the PWM rule.
  - The mask is computed from active data only.
- **LZB disabled (macro undefined).** All digits are decoded as-is and the blanking logic is absent.

## Structure
- **Shared package bcd_scan_pkg:**
  - 7-bit glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - The clogb2 function.
- **Sub-module bcd_to_seg7:** combinational decoder taking 4-bit code and blank inputs and producing a 7-bit active-high pattern. Polarity is applied in the top level.

## Test plan
- **Reset and load.** DISPLAYS_NUM=4, DIV_W=3, reset, load data 0x1234, bright=7, BRIGHT_W=3.
  - Required: o_sel cycles through 0001/0010/0100/1000 (active-high view), each for 8 clocks.
  - Required: glyphs 4, 3, 2, 1 in that order.
  - Required: o_frame pulses every 32 clocks.
- **Mid-frame load.** Load during digit 1.
  - Required: o_busy stays high until the boundary and old data persists through digit 3.
  - Required: the new value appears from digit 0 of the next frame.
- **Double load and coincident load.** Two loads while busy (0x1111, then 0x2222): only 0x2222 is ever displayed. A load on the boundary cycle: committed directly, and o_busy never rises.
- **Brightness.** bright=2 with DIV_W=3.
  - Required: o_sel is active for 2 of every 8 clocks per slot.
  - Required: bright=0 gives o_sel always inactive.
- **Leading-zero blanking (LZB enabled).**
  - data 0x0050 with dp=0: digits 3 and 2 blank, digit 0 shows "0".
  - dp[2]=1: digit 2 shows "0" with dp lit.
  - data 0x0000: only digit 0 is lit.
- **Code and reset edge cases.**
  - Codes 0xA and 0xF show dash and blank respectively.
  - Async reset mid-slot: all outputs go inactive immediately, and o_busy returns to 0.
